// File: rtl/hslp_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : hslp_err_monitor
//  Purpose  : Pipelined error-statistics stage for 8x8 approximate
//             multipliers. Recomputes the exact product of each accepted
//             operand pair and, over a run of N_SAMPLES beats, accumulates
//             the sum of error distance, the signed error sum, the maximum
//             error distance and the count of erroneous results.
//  Ports    : clk, rst_n (async, active-low)
//             start                 - single-cycle run request (IDLE/DONE)
//             in_valid / in_ready   - operand beat handshake
//             a, b, prod_apx        - operands and approximate product
//             busy, done            - run status
//             sum_ed, sum_err, max_ed, err_cnt, smp_cnt - run statistics
//  Revision : 1.0 - initial release
// ============================================================================
module hslp_err_monitor #(
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17,
    parameter int ACC_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         a,
    input  logic [7:0]         b,
    input  logic [15:0]        prod_apx,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   sum_ed,
    output logic [ACC_W:0]     sum_err,
    output logic [15:0]        max_ed,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   smp_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_n_samples = CNT_W'(N_SAMPLES);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_smp_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [ACC_W-1:0]  r_sum_ed;
    logic [ACC_W:0]    r_sum_err;
    logic [15:0]       r_max_ed;

    // Stage 1: exact product alongside the approximate one
    logic              r_s1_valid;
    logic [15:0]       r_s1_exact;
    logic [15:0]       r_s1_apx;

    // Stage 2: signed error and its magnitude
    logic              r_s2_valid;
    logic [16:0]       r_s2_err;
    logic [15:0]       r_s2_ed;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic [16:0]       w_err;
    logic [16:0]       w_err_neg;
    logic [15:0]       w_ed;
    logic              w_last_accept;

    // in_ready depends only on registered state, never on in_valid
    assign w_in_ready    = (r_state == S_RUN) && (r_smp_cnt < c_n_samples);
    assign w_accept      = in_valid && w_in_ready;
    assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_accept = w_accept && (r_smp_cnt == c_n_samples - CNT_W'(1));

    // Both products are < 2^16, so a 17-bit difference never overflows and
    // its magnitude always fits in 16 bits.
    assign w_err     = {1'b0, r_s1_apx} - {1'b0, r_s1_exact};
    assign w_err_neg = 17'd0 - w_err;
    assign w_ed      = w_err[16] ? w_err_neg[15:0] : w_err[15:0];

    // ------------------------------------------------------------------
    // Control FSM and sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_smp_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_state   <= S_RUN;
                        r_smp_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                        if (w_last_accept) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last beat has left S2 once both flags are clear
                    if (!r_s1_valid && !r_s2_valid) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stages 1 and 2
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_exact <= '0;
            r_s1_apx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_err   <= '0;
            r_s2_ed    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_exact <= {8'd0, a} * {8'd0, b};
                r_s1_apx   <= prod_apx;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_err <= w_err;
                r_s2_ed  <= w_ed;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: accumulators (cleared by an accepted start)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_ed  <= '0;
            r_sum_err <= '0;
            r_max_ed  <= '0;
            r_err_cnt <= '0;
        end else if (w_start_ok) begin
            r_sum_ed  <= '0;
            r_sum_err <= '0;
            r_max_ed  <= '0;
            r_err_cnt <= '0;
        end else if (r_s2_valid) begin
            r_sum_ed  <= r_sum_ed + ACC_W'(r_s2_ed);
            r_sum_err <= r_sum_err + {{(ACC_W - 16){r_s2_err[16]}}, r_s2_err};
            if (r_s2_ed > r_max_ed) begin
                r_max_ed <= r_s2_ed;
            end
            r_err_cnt <= r_err_cnt + CNT_W'(r_s2_ed != 16'd0);
        end
    end

    assign in_ready = w_in_ready;
    assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign sum_ed   = r_sum_ed;
    assign sum_err  = r_sum_err;
    assign max_ed   = r_max_ed;
    assign err_cnt  = r_err_cnt;
    assign smp_cnt  = r_smp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hslp_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hslp_err_monitor
//  Purpose  : Self-checking bench for hslp_err_monitor. Four instances with
//             N_SAMPLES = 2, 3, 4 and 65536 share the data inputs; each has
//             its own start so only the selected one runs. Expected results
//             come from plain-arithmetic statistics over the accepted beats.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hslp_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod_apx;
    logic        start_v   [4];

    logic        o_rdy     [4];
    logic        o_busy    [4];
    logic        o_done    [4];
    logic [31:0] o_sum_ed  [4];
    logic [32:0] o_sum_err [4];
    logic [15:0] o_max     [4];
    logic [16:0] o_err     [4];
    logic [16:0] o_smp     [4];

    always #5 clk = ~clk;

    function automatic int ns_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 3 : (s == 2) ? 4 : 65536;
    endfunction

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int NS_G = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 65536;
            hslp_err_monitor #(
                .N_SAMPLES(NS_G),
                .CNT_W    (17),
                .ACC_W    (32)
            ) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (start_v[g]),
                .in_valid(in_valid),
                .in_ready(o_rdy[g]),
                .a       (a),
                .b       (b),
                .prod_apx(prod_apx),
                .busy    (o_busy[g]),
                .done    (o_done[g]),
                .sum_ed  (o_sum_ed[g]),
                .sum_err (o_sum_err[g]),
                .max_ed  (o_max[g]),
                .err_cnt (o_err[g]),
                .smp_cnt (o_smp[g])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    // Reference statistics over the beats accepted in the current run
    longint m_sum_ed;
    longint m_sum_err;
    int     m_max;
    int     m_errs;
    int     m_cnt;

    // Per-run observations returned by drive_run
    int   lat;
    int   f2d;
    int   last_e;
    logic rdy_after;
    logic busy_after;

    // Reference approximate multiplier for the exhaustive run
    function automatic logic [15:0] apx(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] e;
        e = {8'd0, x} * {8'd0, y};
        return e ^ {12'd0, x[3:0] & y[3:0]};
    endfunction

    task automatic model_clear();
        m_sum_ed  = 0;
        m_sum_err = 0;
        m_max     = 0;
        m_errs    = 0;
        m_cnt     = 0;
    endtask

    task automatic model_add(input logic [7:0] x, input logic [7:0] y, input logic [15:0] p);
        int ex;
        int e;
        int ed;
        ex = int'(x) * int'(y);
        e  = int'(p) - ex;
        ed = (e < 0) ? -e : e;
        m_sum_ed  += ed;
        m_sum_err += e;
        if (ed > m_max) m_max = ed;
        if (ed != 0) m_errs++;
        m_cnt++;
    endtask

    task automatic do_start(input int sel);
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        model_clear();
    endtask

    // mode: 0 exact, 1 random error, 2 fixed pair table, 3 index-derived,
    //       4 exhaustive sweep with apx()
    task automatic drive_run(input int sel, input int mode, input int gap_pct,
                             input logic [31:0] vpat, input int use_pat,
                             input int start_at, input int stop_after);
        int n;
        int cyc;
        int first_e;
        int budget;
        int target;
        int ex;
        logic acc;
        logic [7:0]  ta [2];
        logic [7:0]  tbv [2];
        logic [15:0] tp [2];
        ta[0] = 8'd255; tbv[0] = 8'd255; tp[0] = 16'd65000;
        ta[1] = 8'd3;   tbv[1] = 8'd5;   tp[1] = 16'd16;
        n       = ns_of(sel);
        cyc     = 0;
        first_e = -1;
        last_e  = -1;
        budget  = n + 2000;
        target  = (stop_after > 0) ? stop_after : n;
        while (m_cnt < target && cyc < budget) begin
            if (use_pat != 0) in_valid = (cyc < 32) ? vpat[cyc] : 1'b0;
            else              in_valid = ($urandom_range(99) >= gap_pct);
            case (mode)
                0: begin
                    a = 8'($urandom); b = 8'($urandom);
                    prod_apx = {8'd0, a} * {8'd0, b};
                end
                1: begin
                    a = 8'($urandom); b = 8'($urandom);
                    ex = int'(a) * int'(b);
                    if ($urandom_range(3) == 0) prod_apx = 16'(ex);
                    else prod_apx = 16'(ex + int'($urandom_range(2000)) - 1000);
                end
                2: begin
                    a = ta[m_cnt % 2]; b = tbv[m_cnt % 2]; prod_apx = tp[m_cnt % 2];
                end
                3: begin
                    a = 8'(m_cnt * 37 + 11); b = 8'(m_cnt * 91 + 5);
                    prod_apx = 16'(int'(a) * int'(b) + m_cnt * 300 - 200);
                end
                default: begin
                    a = 8'(m_cnt >> 8); b = 8'(m_cnt);
                    prod_apx = apx(a, b);
                end
            endcase
            start_v[sel] = (cyc == start_at);
            acc = in_valid && o_rdy[sel];
            @(posedge clk); #1;
            cyc++;
            start_v[sel] = 1'b0;
            if (acc) begin
                model_add(a, b, prod_apx);
                if (first_e < 0) first_e = cyc;
                last_e = cyc;
                if (m_cnt == n) begin
                    rdy_after  = o_rdy[sel];
                    busy_after = o_busy[sel];
                end
            end
        end
        in_valid = 1'b0;
        if (m_cnt < target) begin
            total++; bad++;
            $display("FAIL accept_timeout sel=%0d accepted=%0d required=%0d", sel, m_cnt, target);
        end
        if (stop_after == 0) begin
            while (!o_done[sel] && (cyc - last_e) < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            lat = cyc - last_e;
            f2d = cyc - first_e;
            if (!o_done[sel]) begin
                total++; bad++;
                $display("FAIL done_timeout sel=%0d done=%0b required=1", sel, o_done[sel]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; prod_apx = '0;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({o_rdy[i], o_busy[i], o_done[i]} !== 3'b000 || o_sum_ed[i] !== 32'd0 ||
                o_sum_err[i] !== 33'd0 || o_max[i] !== 16'd0 || o_err[i] !== 17'd0 ||
                o_smp[i] !== 17'd0) begin
                bad++;
                $display("FAIL reset_state sel=%0d rdy/busy/done=%b%b%b sum_ed=%0d sum_err=%0d max=%0d err=%0d smp=%0d required all 0",
                         i, o_rdy[i], o_busy[i], o_done[i], o_sum_ed[i], o_sum_err[i], o_max[i], o_err[i], o_smp[i]);
            end
        end
    endtask

    task automatic test_exact();
        do_start(2);
        total++;
        if (o_rdy[2] !== 1'b1 || o_busy[2] !== 1'b1 || o_smp[2] !== 17'd0) begin
            bad++;
            $display("FAIL start_run rdy=%b busy=%b smp=%0d required 1 1 0", o_rdy[2], o_busy[2], o_smp[2]);
        end
        drive_run(2, 0, 0, 32'd0, 0, -1, 0);
        total++;
        if (o_sum_ed[2] !== 32'd0 || o_sum_err[2] !== 33'd0 || o_max[2] !== 16'd0 ||
            o_err[2] !== 17'd0 || o_smp[2] !== 17'd4) begin
            bad++;
            $display("FAIL exact_results sum_ed=%0d sum_err=%0d max=%0d err=%0d smp=%0d required 0 0 0 0 4",
                     o_sum_ed[2], o_sum_err[2], o_max[2], o_err[2], o_smp[2]);
        end
        total++;
        if (lat !== 3 || rdy_after !== 1'b0 || busy_after !== 1'b1 || o_busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL exact_timing lat=%0d rdy_after=%b busy_after=%b busy_done=%b required 3 0 1 0",
                     lat, rdy_after, busy_after, o_busy[2]);
        end
    endtask

    task automatic test_known();
        do_start(0);
        drive_run(0, 2, 0, 32'd0, 0, -1, 0);
        total++;
        if (o_sum_ed[0] !== 32'd26 || o_sum_err[0] !== 33'(-24) || o_max[0] !== 16'd25 ||
            o_err[0] !== 17'd2 || o_smp[0] !== 17'd2) begin
            bad++;
            $display("FAIL known_pairs sum_ed=%0d sum_err=%0d max=%0d err=%0d smp=%0d required 26 -24 25 2 2",
                     o_sum_ed[0], $signed(o_sum_err[0]), o_max[0], o_err[0], o_smp[0]);
        end
        total++;
        if (o_done[0] !== 1'b1 || lat !== 3) begin
            bad++;
            $display("FAIL known_done done=%b lat=%0d required 1 3", o_done[0], lat);
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] s_ed;
        logic [32:0] s_err;
        logic [15:0] s_max;
        logic [16:0] s_cnt;
        do_start(1);
        drive_run(1, 3, 0, 32'h0000_0029, 1, -1, 0);
        total++;
        if (o_smp[1] !== 17'd3 || last_e !== 6 || lat !== 3) begin
            bad++;
            $display("FAIL bubble_accepts smp=%0d last_accept_edge=%0d lat=%0d required 3 6 3",
                     o_smp[1], last_e, lat);
        end
        total++;
        if (o_sum_ed[1] !== 32'(m_sum_ed) || o_sum_err[1] !== 33'(m_sum_err) ||
            o_max[1] !== 16'(m_max) || o_err[1] !== 17'(m_errs)) begin
            bad++;
            $display("FAIL bubble_results sum_ed=%0d/%0d sum_err=%0d/%0d max=%0d/%0d err=%0d/%0d (actual/required)",
                     o_sum_ed[1], m_sum_ed, $signed(o_sum_err[1]), m_sum_err, o_max[1], m_max, o_err[1], m_errs);
        end
        s_ed = o_sum_ed[1]; s_err = o_sum_err[1]; s_max = o_max[1]; s_cnt = o_err[1];
        do_start(1);
        drive_run(1, 3, 0, 32'd0, 0, -1, 0);
        total++;
        if (o_sum_ed[1] !== s_ed || o_sum_err[1] !== s_err || o_max[1] !== s_max ||
            o_err[1] !== s_cnt || lat !== 3) begin
            bad++;
            $display("FAIL bubble_vs_gapless sum_ed=%0d/%0d sum_err=%0d/%0d max=%0d/%0d err=%0d/%0d lat=%0d/3",
                     o_sum_ed[1], s_ed, o_sum_err[1], s_err, o_max[1], s_max, o_err[1], s_cnt, lat);
        end
    endtask

    task automatic test_start_control();
        do_start(2);
        drive_run(2, 1, 30, 32'd0, 0, 2, 0);
        total++;
        if (o_smp[2] !== 17'd4 || o_sum_ed[2] !== 32'(m_sum_ed) || o_sum_err[2] !== 33'(m_sum_err) ||
            o_max[2] !== 16'(m_max) || o_err[2] !== 17'(m_errs)) begin
            bad++;
            $display("FAIL start_in_run smp=%0d sum_ed=%0d/%0d sum_err=%0d/%0d max=%0d/%0d err=%0d/%0d",
                     o_smp[2], o_sum_ed[2], m_sum_ed, $signed(o_sum_err[2]), m_sum_err, o_max[2], m_max, o_err[2], m_errs);
        end
        for (int r = 0; r < 3; r++) begin
            do_start(2);
            total++;
            if (o_sum_ed[2] !== 32'd0 || o_sum_err[2] !== 33'd0 || o_max[2] !== 16'd0 ||
                o_err[2] !== 17'd0 || o_smp[2] !== 17'd0 || o_done[2] !== 1'b0 || o_rdy[2] !== 1'b1) begin
                bad++;
                $display("FAIL start_in_done_clear r=%0d sum_ed=%0d sum_err=%0d max=%0d err=%0d smp=%0d done=%b rdy=%b",
                         r, o_sum_ed[2], o_sum_err[2], o_max[2], o_err[2], o_smp[2], o_done[2], o_rdy[2]);
            end
            drive_run(2, 1, 40, 32'd0, 0, -1, 0);
            total++;
            if (o_sum_ed[2] !== 32'(m_sum_ed) || o_sum_err[2] !== 33'(m_sum_err) ||
                o_max[2] !== 16'(m_max) || o_err[2] !== 17'(m_errs) || lat !== 3) begin
                bad++;
                $display("FAIL random_run r=%0d sum_ed=%0d/%0d sum_err=%0d/%0d max=%0d/%0d err=%0d/%0d lat=%0d/3",
                         r, o_sum_ed[2], m_sum_ed, $signed(o_sum_err[2]), m_sum_err, o_max[2], m_max, o_err[2], m_errs, lat);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(3);
        drive_run(3, 1, 20, 32'd0, 0, -1, 10);
        total++;
        if (o_smp[3] !== 17'd10 || o_busy[3] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset smp=%0d busy=%b required 10 1", o_smp[3], o_busy[3]);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({o_rdy[3], o_busy[3], o_done[3]} !== 3'b000 || o_sum_ed[3] !== 32'd0 ||
            o_sum_err[3] !== 33'd0 || o_max[3] !== 16'd0 || o_err[3] !== 17'd0 || o_smp[3] !== 17'd0) begin
            bad++;
            $display("FAIL async_reset rdy/busy/done=%b%b%b sum_ed=%0d sum_err=%0d max=%0d err=%0d smp=%0d required all 0",
                     o_rdy[3], o_busy[3], o_done[3], o_sum_ed[3], o_sum_err[3], o_max[3], o_err[3], o_smp[3]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        longint g_ed;
        longint g_err;
        int     g_max;
        int     g_cnt;
        int     e;
        g_ed = 0; g_err = 0; g_max = 0; g_cnt = 0;
        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 256; y++) begin
                e = int'(apx(8'(x), 8'(y))) - x * y;
                if (e < 0) e = -e;
                g_ed += e;
                g_err += int'(apx(8'(x), 8'(y))) - x * y;
                if (e > g_max) g_max = e;
                if (e != 0) g_cnt++;
            end
        end
        do_start(3);
        drive_run(3, 4, 0, 32'd0, 0, -1, 0);
        total++;
        if (o_sum_ed[3] !== 32'(g_ed) || o_sum_err[3] !== 33'(g_err) ||
            o_max[3] !== 16'(g_max) || o_err[3] !== 17'(g_cnt)) begin
            bad++;
            $display("FAIL exhaustive_totals sum_ed=%0d/%0d sum_err=%0d/%0d max=%0d/%0d err=%0d/%0d",
                     o_sum_ed[3], g_ed, $signed(o_sum_err[3]), g_err, o_max[3], g_max, o_err[3], g_cnt);
        end
        total++;
        if (o_smp[3] !== 17'd65536 || f2d !== 65538 || lat !== 3) begin
            bad++;
            $display("FAIL exhaustive_timing smp=%0d first_to_done_edges=%0d lat=%0d required 65536 65538 3",
                     o_smp[3], f2d, lat);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_known();
        test_bubbles();
        test_start_control();
        test_reset_mid_run();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
